// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - request/response bus of the data memory controller
// Both ends of the load/store handshake; the controller takes the slave modport.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int OFF_W = $clog2(DATA_W / 8);

  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_we_i;
  logic [ADDR_W+OFF_W-1:0] req_addr_i;
  logic [1:0]              req_size_i;
  logic                    req_unsigned_i;
  logic [DATA_W-1:0]       req_wdata_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [DATA_W-1:0]       rsp_rdata_o;
  logic                    rsp_err_o;
  logic                    init_done_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    input  rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_size_i, req_unsigned_i, req_wdata_i,
    output rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, init_done_o
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed data memory with sized loads/stores
// Clears the array after reset, then serves one request per cycle through a single response register.
module data_mem_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  data_mem_ctrl_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {INIT, READY} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                req_ready, init_done, accept, fault, sign_bit;
  logic [ADDR_W-1:0]   widx;
  logic [OFF_W-1:0]    off;
  logic [3:0]          nbytes;
  logic [6:0]          nbits;
  logic [DATA_W-1:0]   rd_word, rd_shift, wr_shift, wr_merged, ld_data;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  assign widx     = bus.req_addr_i[ADDR_W+OFF_W-1:OFF_W];
  assign off      = bus.req_addr_i[OFF_W-1:0];
  assign nbytes   = 4'd1 << bus.req_size_i;
  assign nbits    = {nbytes, 3'b000};
  assign fault    = (nbytes > 4'(NB)) || ((4'(off) & (nbytes - 4'd1)) != 4'd0);
  assign rd_word  = mem_q[widx];
  assign rd_shift = rd_word >> {off, 3'b000};
  assign wr_shift = bus.req_wdata_i << {off, 3'b000};
  assign accept   = bus.req_valid_i && req_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Ready is gated by rst_i so nothing is accepted on the edge that resets the controller.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    init_done = 1'b0;
    unique case (state_q)
      INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
        init_done = 1'b1;
        req_ready = !rst_i && (!rsp_valid_q || bus.rsp_ready_i);
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    wr_merged = rd_word;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(off)) && (b < int'(off) + int'(nbytes))) begin
        wr_merged[8*b +: 8] = wr_shift[8*b +: 8];
      end
    end
  end

  always_comb begin
    unique case (bus.req_size_i)
      2'd0:    sign_bit = rd_shift[7];
      2'd1:    sign_bit = rd_shift[15];
      2'd2:    sign_bit = rd_shift[31];
      default: sign_bit = rd_shift[DATA_W-1];
    endcase
    ld_data = '0;
    for (int i = 0; i < DATA_W; i++) begin
      ld_data[i] = (i < int'(nbits)) ? rd_shift[i] : (!bus.req_unsigned_i && sign_bit);
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      rsp_rdata_d = (fault || bus.req_we_i) ? '0 : ld_data;
    end else if (bus.rsp_ready_i) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wdata = '0;
    if (state_q == INIT) begin
      mem_we = 1'b1;
    end else if (accept && bus.req_we_i && !fault) begin
      mem_we    = 1'b1;
      mem_waddr = widx;
      mem_wdata = wr_merged;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.init_done_o = init_done;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign bus.rsp_rdata_o = rsp_rdata_q;
endmodule
